plane_dispatch_arbiter: RTL and testbench
=========================================

Name: plane_dispatch_arbiter

Overview:
- Shares the NAND planes between host job queues.
- Takes one decoded job per host (host id implied by port index, plus plane id and metadata), picks a winner by round-robin among hosts whose target plane is idle, and issues it on a single dispatch channel.
- Tracks per-plane busy state until the flash backend reports completion.
- Sits between the per-host job decoders and the plane command sequencer.

Parameters:
- MAX_HOST_NUMBER, `MAX_HOST_NUMBER (4), number of requesting hosts.
- MAX_PLANE_NUMBER, `MAX_PLANE_NUMBER (8), number of planes tracked.
- HOST_ID_BIT_WIDTH, $clog2(MAX_HOST_NUMBER), host id width.
- PLANE_ID_BIT_WIDTH, $clog2(MAX_PLANE_NUMBER), plane id width.
- META_DATA_BIT_WIDTH, 64, opaque job metadata width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  MAX_HOST_NUMBER  per-host job valid.
- i_req_plane_id  in  MAX_HOST_NUMBER*PLANE_ID_BIT_WIDTH  per-host target plane; host h at slice [h*PLANE_ID_BIT_WIDTH+:PLANE_ID_BIT_WIDTH].
- i_req_meta  in  MAX_HOST_NUMBER*META_DATA_BIT_WIDTH  per-host metadata; same slicing.
- o_req_ready  out  MAX_HOST_NUMBER  one-hot accept pulse; job consumed.
- o_disp_valid  out  1  dispatch valid.
- o_disp_host_id  out  HOST_ID_BIT_WIDTH  granted host.
- o_disp_plane_id  out  PLANE_ID_BIT_WIDTH  granted plane.
- o_disp_meta  out  META_DATA_BIT_WIDTH  granted metadata.
- i_disp_ready  in  1  downstream accepts dispatch.
- i_cpl_valid  in  1  plane operation complete.
- i_cpl_plane_id  in  PLANE_ID_BIT_WIDTH  completed plane.
- o_plane_busy  out  MAX_PLANE_NUMBER  busy bitmap.
- o_inflight_count  out  PLANE_ID_BIT_WIDTH+1  number of busy planes.
- o_err_cpl  out  1  sticky: completion received for an idle plane.

Behaviour:
- Reset (async, immediate, including mid-dispatch):
  - All outputs 0; state IDLE; rr_ptr=0; busy bitmap and error flag cleared.
  - A latched job is dropped and its o_req_ready is never pulsed.
- Request protocol:
  - A host holds valid, plane and meta stable until its o_req_ready pulse.
  - If a host drops valid while in DISPATCH, the block ignores it because the payload is already latched.
- Eligibility: host h is eligible when i_req_valid[h]=1 and o_plane_busy[its plane]=0. The registered busy value is used; no same-cycle bypass.
- FSM, one-hot states IDLE, DISPATCH:
  - IDLE:
    - If any host is eligible, search from rr_ptr upward with wrap to MAX_HOST_NUMBER-1→0.
    - Register the first eligible host's id, plane and meta into the o_disp_* registers.
    - Set o_disp_valid=1 and go to DISPATCH.
    - Otherwise stay in IDLE.
  - DISPATCH:
    - o_disp_* stay stable while i_disp_ready=0.
    - On i_disp_ready=1 (handshake edge):
      - o_req_ready[granted] pulses high for exactly that cycle.
      - busy[plane] is set at the edge.
      - rr_ptr becomes (granted+1) mod MAX_HOST_NUMBER.
      - o_disp_valid is cleared at the edge and the FSM returns to IDLE.
- Latency and throughput:
  - o_disp_valid rises 1 cycle after an eligible request is sampled in IDLE.
  - Peak throughput is 1 job per 2 cycles (one IDLE bubble between jobs).
- Completion:
  - i_cpl_valid=1 with busy[p]=1 clears busy[p] at the edge.
  - With busy[p]=0, busy is unchanged and o_err_cpl is set and stays set until reset.
  - Completion and dispatch handshake to the same plane in the same cycle: the completion is treated as spurious (plane was idle), so o_err_cpl is set and busy[p] ends at 1 (set wins).
  - Completion and dispatch to different planes in the same cycle: both take effect.
- o_inflight_count:
  - Registered popcount of busy, updated at the same edge as busy: +1 on handshake, -1 on valid completion, net 0 when both happen.
  - Range 0..MAX_PLANE_NUMBER, so no wrap.
- Blocking: a host whose plane is busy is skipped and does not block other hosts. It is dispatched in the first IDLE cycle after its plane clears in which it wins round-robin.

Test Plan:
- Reset: assert i_rst_n=0 mid-DISPATCH → all outputs 0 asynchronously. After release, with no requests, the block stays in IDLE with o_disp_valid=0.
- Single job: host 0, plane 3, meta 0xA5, i_disp_ready=1 → o_disp_valid next cycle with host 0, plane 3, meta 0xA5; o_req_ready=4'b0001 for 1 cycle; busy=8'h08; inflight=1.
- Round-robin: hosts 0,1,2 valid on planes 1,2,4, i_disp_ready=1 → grants in order 0,1,2 with a 2-cycle spacing; final busy=8'h16; inflight=3; next search starts at host 3.
- Plane conflict: hosts 0 and 1 both target plane 5 → host 0 dispatched; host 1 held. i_cpl_valid on plane 5 → host 1 o_disp_valid 2 cycles after the completion cycle; inflight 1→0→1.
- Backpressure: i_disp_ready=0 for 4 cycles → o_disp_* stable, o_req_ready=0, busy unchanged. On i_disp_ready=1 → handshake completes in that cycle.
- Spurious completion: i_cpl_valid for idle plane 2 → o_err_cpl=1 and stays 1; busy and inflight unchanged; later dispatches unaffected.

Source files
------------

// File: rtl/plane_dispatch_arbiter.sv
// Round-robin dispatch of host jobs onto idle NAND planes.
// Tracks per-plane busy state until the backend reports completion.
module plane_dispatch_arbiter #(
  parameter int MAX_HOST_NUMBER     = 4,
  parameter int MAX_PLANE_NUMBER    = 8,
  parameter int HOST_ID_BIT_WIDTH   = $clog2(MAX_HOST_NUMBER),
  parameter int PLANE_ID_BIT_WIDTH  = $clog2(MAX_PLANE_NUMBER),
  parameter int META_DATA_BIT_WIDTH = 64
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst_n,
  input  logic [MAX_HOST_NUMBER-1:0]                    i_req_valid,
  input  logic [MAX_HOST_NUMBER*PLANE_ID_BIT_WIDTH-1:0] i_req_plane_id,
  input  logic [MAX_HOST_NUMBER*META_DATA_BIT_WIDTH-1:0] i_req_meta,
  output logic [MAX_HOST_NUMBER-1:0]                    o_req_ready,
  output logic                                          o_disp_valid,
  output logic [HOST_ID_BIT_WIDTH-1:0]                  o_disp_host_id,
  output logic [PLANE_ID_BIT_WIDTH-1:0]                 o_disp_plane_id,
  output logic [META_DATA_BIT_WIDTH-1:0]                o_disp_meta,
  input  logic                                          i_disp_ready,
  input  logic                                          i_cpl_valid,
  input  logic [PLANE_ID_BIT_WIDTH-1:0]                 i_cpl_plane_id,
  output logic [MAX_PLANE_NUMBER-1:0]                   o_plane_busy,
  output logic [PLANE_ID_BIT_WIDTH:0]                   o_inflight_count,
  output logic                                          o_err_cpl
);

  localparam int H  = MAX_HOST_NUMBER;
  localparam int HW = HOST_ID_BIT_WIDTH;
  localparam int PW = PLANE_ID_BIT_WIDTH;
  localparam int MW = META_DATA_BIT_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'b01,
    DISPATCH = 2'b10
  } state_e;

  state_e                        state_q, state_d;
  logic [HW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic                          disp_valid_q, disp_valid_d;
  logic [HW-1:0]                 disp_host_q, disp_host_d;
  logic [PW-1:0]                 disp_plane_q, disp_plane_d;
  logic [MW-1:0]                 disp_meta_q, disp_meta_d;
  logic [MAX_PLANE_NUMBER-1:0]   busy_q, busy_d;
  logic [PW:0]                   cnt_q, cnt_d;
  logic                          err_q, err_d;

  logic [H-1:0]  elig;
  logic          pick_found;
  logic [HW-1:0] pick_host;
  logic [PW-1:0] pick_plane;
  logic [MW-1:0] pick_meta;
  logic          hs;
  logic          cpl_hit;

  assign hs      = (state_q == DISPATCH) && i_disp_ready;
  assign cpl_hit = i_cpl_valid && busy_q[i_cpl_plane_id];

  // A host may compete only if its plane is idle in the registered bitmap.
  always_comb begin
    elig = '0;
    for (int h = 0; h < H; h++) begin
      elig[h] = i_req_valid[h] &&
                !busy_q[i_req_plane_id[h*PW +: PW]];
    end
  end

  // Rotating priority search starting at rr_ptr, wrapping at H-1.
  always_comb begin
    int idx_i;
    idx_i      = 0;
    pick_found = 1'b0;
    pick_host  = '0;
    pick_plane = '0;
    pick_meta  = '0;
    for (int i = 0; i < H; i++) begin
      idx_i = int'(rr_ptr_q) + i;
      if (idx_i >= H) idx_i = idx_i - H;
      for (int h = 0; h < H; h++) begin
        if (!pick_found && h == idx_i && elig[h]) begin
          pick_found = 1'b1;
          pick_host  = HW'(h);
          pick_plane = i_req_plane_id[h*PW +: PW];
          pick_meta  = i_req_meta[h*MW +: MW];
        end
      end
    end
  end

  // FSM next state and dispatch register updates.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    disp_valid_d = disp_valid_q;
    disp_host_d  = disp_host_q;
    disp_plane_d = disp_plane_q;
    disp_meta_d  = disp_meta_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (pick_found) begin
          disp_host_d  = pick_host;
          disp_plane_d = pick_plane;
          disp_meta_d  = pick_meta;
          disp_valid_d = 1'b1;
          state_d      = DISPATCH;
        end
      end
      (state_q == DISPATCH): begin
        if (i_disp_ready) begin
          disp_valid_d = 1'b0;
          state_d      = IDLE;
          if (disp_host_q == HW'(H - 1)) rr_ptr_d = '0;
          else rr_ptr_d = disp_host_q + HW'(1);
        end
      end
      default: begin
        disp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // Busy bitmap, inflight count and sticky error; set wins over clear.
  always_comb begin
    busy_d = busy_q;
    if (cpl_hit) busy_d[i_cpl_plane_id] = 1'b0;
    if (hs) busy_d[disp_plane_q] = 1'b1;
    cnt_d = cnt_q + {{PW{1'b0}}, hs} - {{PW{1'b0}}, cpl_hit};
    err_d = err_q | (i_cpl_valid & ~busy_q[i_cpl_plane_id]);
  end

  // Accept pulse for the granted host in the handshake cycle.
  always_comb begin
    o_req_ready = '0;
    if (hs) o_req_ready[disp_host_q] = 1'b1;
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      disp_valid_q <= 1'b0;
      disp_host_q  <= '0;
      disp_plane_q <= '0;
      disp_meta_q  <= '0;
      busy_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      disp_valid_q <= disp_valid_d;
      disp_host_q  <= disp_host_d;
      disp_plane_q <= disp_plane_d;
      disp_meta_q  <= disp_meta_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign o_disp_valid     = disp_valid_q;
  assign o_disp_host_id   = disp_host_q;
  assign o_disp_plane_id  = disp_plane_q;
  assign o_disp_meta      = disp_meta_q;
  assign o_plane_busy     = busy_q;
  assign o_inflight_count = cnt_q;
  assign o_err_cpl        = err_q;

endmodule

// File: tb/tb_plane_dispatch_arbiter.sv
// Directed bench for plane_dispatch_arbiter.
// Expected dispatches are queued by stimulus and checked by a monitor.
module tb_plane_dispatch_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   i_req_valid;
  logic [11:0]  i_req_plane_id;
  logic [255:0] i_req_meta;
  logic [3:0]   o_req_ready;
  logic         o_disp_valid;
  logic [1:0]   o_disp_host_id;
  logic [2:0]   o_disp_plane_id;
  logic [63:0]  o_disp_meta;
  logic         i_disp_ready;
  logic         i_cpl_valid;
  logic [2:0]   i_cpl_plane_id;
  logic [7:0]   o_plane_busy;
  logic [3:0]   o_inflight_count;
  logic         o_err_cpl;

  typedef struct {
    logic [1:0]  host;
    logic [2:0]  plane;
    logic [63:0] meta;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  plane_dispatch_arbiter dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req_valid      (i_req_valid),
    .i_req_plane_id   (i_req_plane_id),
    .i_req_meta       (i_req_meta),
    .o_req_ready      (o_req_ready),
    .o_disp_valid     (o_disp_valid),
    .o_disp_host_id   (o_disp_host_id),
    .o_disp_plane_id  (o_disp_plane_id),
    .o_disp_meta      (o_disp_meta),
    .i_disp_ready     (i_disp_ready),
    .i_cpl_valid      (i_cpl_valid),
    .i_cpl_plane_id   (i_cpl_plane_id),
    .o_plane_busy     (o_plane_busy),
    .o_inflight_count (o_inflight_count),
    .o_err_cpl        (o_err_cpl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic set_req(input int h, input logic v,
                         input logic [2:0] p,
                         input logic [63:0] m);
    i_req_valid[h]          = v;
    i_req_plane_id[h*3 +: 3] = p;
    i_req_meta[h*64 +: 64]  = m;
  endtask

  task automatic push(input logic [1:0] h,
                      input logic [2:0] p,
                      input logic [63:0] m);
    exp_t e;
    e.host  = h;
    e.plane = p;
    e.meta  = m;
    exp_q.push_back(e);
  endtask

  // One cycle; a host drops valid after its accept pulse.
  task automatic tick();
    logic [3:0] rdy;
    @(negedge clk);
    rdy = o_req_ready;
    @(posedge clk);
    #1;
    i_req_valid = i_req_valid & ~rdy;
  endtask

  task automatic cpl(input logic [2:0] p);
    i_cpl_valid    = 1'b1;
    i_cpl_plane_id = p;
    tick();
    i_cpl_valid = 1'b0;
  endtask

  // Monitor: every handshake must match the next queued grant.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] oh;
    if (rst_n && o_disp_valid && i_disp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_dispatch: got host %0d expected none",
                 o_disp_host_id);
      end else begin
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.host;
        chk("disp_host", o_disp_host_id, e.host);
        chk("disp_plane", o_disp_plane_id, e.plane);
        chk("disp_meta", o_disp_meta, e.meta);
        chk("req_ready", o_req_ready, oh);
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    i_req_valid    = '0;
    i_req_plane_id = '0;
    i_req_meta     = '0;
    i_disp_ready   = 1'b0;
    i_cpl_valid    = 1'b0;
    i_cpl_plane_id = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_disp_valid", o_disp_valid, 0);
    chk("rst_busy", o_plane_busy, 0);
    chk("rst_inflight", o_inflight_count, 0);
    chk("rst_err", o_err_cpl, 0);
    chk("rst_req_ready", o_req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_no_req", o_disp_valid, 0);

    // Single job.
    i_disp_ready = 1'b1;
    set_req(0, 1'b1, 3'd3, 64'hA5);
    push(2'd0, 3'd3, 64'hA5);
    tick();
    chk("single_latency", o_disp_valid, 1);
    tick();
    chk("single_busy", o_plane_busy, 8'h08);
    chk("single_inflight", o_inflight_count, 1);
    chk("single_valid_clr", o_disp_valid, 0);

    // Asynchronous reset while a job sits in DISPATCH.
    i_disp_ready = 1'b0;
    set_req(2, 1'b1, 3'd7, 64'h77);
    tick();
    chk("pre_rst_valid", o_disp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_disp_valid", o_disp_valid, 0);
    chk("arst_host", o_disp_host_id, 0);
    chk("arst_plane", o_disp_plane_id, 0);
    chk("arst_meta", o_disp_meta, 0);
    chk("arst_busy", o_plane_busy, 0);
    chk("arst_inflight", o_inflight_count, 0);
    chk("arst_req_ready", o_req_ready, 0);
    i_req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_idle", o_disp_valid, 0);

    // Round robin among hosts 0,1,2.
    i_disp_ready = 1'b1;
    set_req(0, 1'b1, 3'd1, 64'h100);
    set_req(1, 1'b1, 3'd2, 64'h101);
    set_req(2, 1'b1, 3'd4, 64'h102);
    push(2'd0, 3'd1, 64'h100);
    push(2'd1, 3'd2, 64'h101);
    push(2'd2, 3'd4, 64'h102);
    tick();
    chk("rr_g0_host", o_disp_host_id, 0);
    tick();
    chk("rr_bubble", o_disp_valid, 0);
    tick();
    chk("rr_g1_host", o_disp_host_id, 1);
    tick();
    tick();
    chk("rr_g2_host", o_disp_host_id, 2);
    tick();
    chk("rr_busy", o_plane_busy, 8'h16);
    chk("rr_inflight", o_inflight_count, 3);
    cpl(3'd1);
    chk("cpl_inflight", o_inflight_count, 2);
    cpl(3'd2);
    cpl(3'd4);
    chk("cpl_all_busy", o_plane_busy, 0);
    chk("cpl_all_inflight", o_inflight_count, 0);

    // Plane conflict on plane 5.
    set_req(0, 1'b1, 3'd5, 64'h200);
    set_req(1, 1'b1, 3'd5, 64'h201);
    push(2'd0, 3'd5, 64'h200);
    push(2'd1, 3'd5, 64'h201);
    tick();
    chk("conf_first_host", o_disp_host_id, 0);
    tick();
    chk("conf_inflight_1", o_inflight_count, 1);
    tick();
    chk("conf_hold", o_disp_valid, 0);
    cpl(3'd5);
    chk("conf_inflight_0", o_inflight_count, 0);
    chk("conf_cpl_valid", o_disp_valid, 0);
    tick();
    chk("conf_release", o_disp_valid, 1);
    chk("conf_release_host", o_disp_host_id, 1);
    tick();
    chk("conf_inflight_again", o_inflight_count, 1);
    chk("conf_busy", o_plane_busy, 8'h20);

    // Backpressure.
    i_disp_ready = 1'b0;
    set_req(2, 1'b1, 3'd0, 64'hBEEF);
    push(2'd2, 3'd0, 64'hBEEF);
    tick();
    chk("bp_valid", o_disp_valid, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid_hold", o_disp_valid, 1);
      chk("bp_host_hold", o_disp_host_id, 2);
      chk("bp_meta_hold", o_disp_meta, 64'hBEEF);
      chk("bp_no_ready", o_req_ready, 0);
      chk("bp_busy_hold", o_plane_busy, 8'h20);
    end
    i_disp_ready = 1'b1;
    tick();
    chk("bp_busy_done", o_plane_busy, 8'h21);
    chk("bp_inflight", o_inflight_count, 2);

    // Spurious completion on idle plane 2.
    cpl(3'd2);
    chk("spur_err", o_err_cpl, 1);
    chk("spur_busy", o_plane_busy, 8'h21);
    chk("spur_inflight", o_inflight_count, 2);
    tick();
    chk("spur_sticky", o_err_cpl, 1);
    set_req(3, 1'b1, 3'd2, 64'h300);
    push(2'd3, 3'd2, 64'h300);
    repeat (2) tick();
    chk("spur_then_busy", o_plane_busy, 8'h25);
    chk("spur_then_inflight", o_inflight_count, 3);

    // Completion and handshake on the same plane: set wins.
    i_disp_ready = 1'b0;
    set_req(0, 1'b1, 3'd7, 64'h400);
    push(2'd0, 3'd7, 64'h400);
    tick();
    i_disp_ready = 1'b1;
    cpl(3'd7);
    chk("same_busy", o_plane_busy, 8'hA5);
    chk("same_inflight", o_inflight_count, 4);

    // Completion and handshake on different planes.
    i_disp_ready = 1'b0;
    set_req(1, 1'b1, 3'd6, 64'h500);
    push(2'd1, 3'd6, 64'h500);
    tick();
    i_disp_ready = 1'b1;
    cpl(3'd0);
    chk("diff_busy", o_plane_busy, 8'hE4);
    chk("diff_inflight", o_inflight_count, 4);
    chk("final_err", o_err_cpl, 1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
